// File: rtl/fp_round_pipe_pkg.sv
// rtl/fp_round_pipe_pkg.sv - shared fp types: rounding modes, exception flags, format widths
package fp_round_pipe_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RUP = 3'd2,
        RM_RDN = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef struct packed {
        logic nx;
        logic of;
        logic uf;
    } fp_flags_t;

    function automatic int exp_wid(input int fpwid);
        case (fpwid)
            16:      return 5;
            64:      return 11;
            128:     return 15;
            default: return 8;
        endcase
    endfunction

    function automatic int frac_wid(input int fpwid);
        case (fpwid)
            16:      return 10;
            64:      return 52;
            128:     return 112;
            default: return 23;
        endcase
    endfunction

endpackage

// File: rtl/fp_round_decide.sv
// rtl/fp_round_decide.sv - combinational round-increment decision from mode, sign, L and G/R/S
module fp_round_decide
    import fp_round_pipe_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       r,
    input  logic       st,
    input  logic       is_special,
    output logic       inc
);

    logic inexact;

    // Pick the increment for the selected mode; Inf/NaN never round, modes 5-7 behave as RNE
    always_comb begin
        inexact = g | r | st;
        inc     = 1'b0;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~sign & inexact;
            RM_RDN:  inc = sign & inexact;
            RM_RMM:  inc = g;
            default: inc = g & (r | st | lsb);
        endcase
        if (is_special) begin
            inc = 1'b0;
        end
    end

endmodule

// File: rtl/fp_round_pipe.sv
// rtl/fp_round_pipe.sv - 3-stage IEEE-754 rounder with valid/ready; FP_ROUND_FLAGS_EN builds nx/of/uf flags
module fp_round_pipe
    import fp_round_pipe_pkg::*;
#(
    parameter int FPWID = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [2:0]       rm,
    input  logic [FPWID+3:0] i,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [FPWID-1:0] o,
    output logic             o_nx,
    output logic             o_of,
    output logic             o_uf
);

    localparam int EW = exp_wid(FPWID);
    localparam int FW = frac_wid(FPWID);
    localparam int SW = FPWID - 1;
    localparam logic [SW-1:0] INF_EF = {{EW{1'b1}}, {FW{1'b0}}};
    localparam logic [SW-1:0] MAX_EF = {{(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};

    // The hidden bit is implied by the exponent field and does not enter the packed result
    logic unused_hid;
    assign unused_hid = i[FW+3];

    logic          s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
    logic [SW-1:0] s1_ef_q, s1_ef_d;
    logic [2:0]    s1_grs_q, s1_grs_d, s1_rm_q, s1_rm_d;
    logic          s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
    logic          s2_inc_q, s2_inc_d, s2_special_q, s2_special_d;
    logic [SW-1:0] s2_ef_q, s2_ef_d;
    logic [2:0]    s2_rm_q, s2_rm_d;
    logic          s3_valid_q, s3_valid_d;
    logic [FPWID-1:0] s3_res_q, s3_res_d;

    logic          s1_free, s2_free, s3_free;
    logic          s1_load, s2_load, s3_load;
    logic          s1_inc, s1_special;
    logic [SW-1:0] s2_sum;
    logic          s2_ovf, s2_to_inf;

    // A stage may take new data when it is empty or its content moves on this cycle
    assign s3_free = ~s3_valid_q | o_ready;
    assign s2_free = ~s2_valid_q | s3_free;
    assign s1_free = ~s1_valid_q | s2_free;
    assign s1_load = s1_free & i_valid;
    assign s2_load = s2_free & s1_valid_q;
    assign s3_load = s3_free & s2_valid_q;
    assign i_ready = s1_free;
    assign o_valid = s3_valid_q;
    assign o       = s3_res_q;

    assign s1_special = &s1_ef_q[SW-1 -: EW];

    fp_round_decide u_decide (
        .rm         (s1_rm_q),
        .sign       (s1_sign_q),
        .lsb        (s1_ef_q[0]),
        .g          (s1_grs_q[2]),
        .r          (s1_grs_q[1]),
        .st         (s1_grs_q[0]),
        .is_special (s1_special),
        .inc        (s1_inc)
    );

    // S2 add and overflow detection; a fraction carry ripples into the exponent
    always_comb begin
        s2_sum    = s2_ef_q + {{(SW-1){1'b0}}, s2_inc_q};
        s2_ovf    = (&s2_sum[SW-1 -: EW]) & ~s2_special_q;
        s2_to_inf = 1'b1;
        case (s2_rm_q)
            RM_RTZ:  s2_to_inf = 1'b0;
            RM_RUP:  s2_to_inf = ~s2_sign_q;
            RM_RDN:  s2_to_inf = s2_sign_q;
            default: s2_to_inf = 1'b1;
        endcase
    end

    // Next-state for the value pipeline: hold by default, load when the stage is free and fed
    always_comb begin
        s1_valid_d   = s1_free ? i_valid : s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_ef_d      = s1_ef_q;
        s1_grs_d     = s1_grs_q;
        s1_rm_d      = s1_rm_q;
        s2_valid_d   = s2_free ? s1_valid_q : s2_valid_q;
        s2_sign_d    = s2_sign_q;
        s2_ef_d      = s2_ef_q;
        s2_inc_d     = s2_inc_q;
        s2_special_d = s2_special_q;
        s2_rm_d      = s2_rm_q;
        s3_valid_d   = s3_free ? s2_valid_q : s3_valid_q;
        s3_res_d     = s3_res_q;
        if (s1_load) begin
            s1_sign_d = i[FPWID+3];
            s1_ef_d   = {i[FPWID+2 -: EW], i[FW+2:3]};
            s1_grs_d  = i[2:0];
            s1_rm_d   = rm;
        end
        if (s2_load) begin
            s2_sign_d    = s1_sign_q;
            s2_ef_d      = s1_ef_q;
            s2_inc_d     = s1_inc;
            s2_special_d = s1_special;
            s2_rm_d      = s1_rm_q;
        end
        if (s3_load) begin
            s3_res_d = {s2_sign_q, s2_ovf ? (s2_to_inf ? INF_EF : MAX_EF) : s2_sum};
        end
    end

    // Value pipeline registers; reset drops in-flight beats and clears the datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_ef_q      <= '0;
            s1_grs_q     <= '0;
            s1_rm_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_ef_q      <= '0;
            s2_inc_q     <= 1'b0;
            s2_special_q <= 1'b0;
            s2_rm_q      <= '0;
            s3_valid_q   <= 1'b0;
            s3_res_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_ef_q      <= s1_ef_d;
            s1_grs_q     <= s1_grs_d;
            s1_rm_q      <= s1_rm_d;
            s2_valid_q   <= s2_valid_d;
            s2_sign_q    <= s2_sign_d;
            s2_ef_q      <= s2_ef_d;
            s2_inc_q     <= s2_inc_d;
            s2_special_q <= s2_special_d;
            s2_rm_q      <= s2_rm_d;
            s3_valid_q   <= s3_valid_d;
            s3_res_q     <= s3_res_d;
        end
    end

`ifdef FP_ROUND_FLAGS_EN
    logic      s2_inexact_q, s2_inexact_d;
    fp_flags_t s3_flags_q, s3_flags_d;

    // Flags follow the value: tininess is judged on the rounded exponent, specials raise nothing
    always_comb begin
        s2_inexact_d = s2_inexact_q;
        s3_flags_d   = s3_flags_q;
        if (s2_load) begin
            s2_inexact_d = |s1_grs_q & ~s1_special;
        end
        if (s3_load) begin
            s3_flags_d.nx = s2_inexact_q;
            s3_flags_d.of = s2_ovf;
            s3_flags_d.uf = s2_inexact_q & (s2_sum[SW-1 -: EW] == '0);
        end
    end

    // Flag pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_inexact_q <= 1'b0;
            s3_flags_q   <= '0;
        end else begin
            s2_inexact_q <= s2_inexact_d;
            s3_flags_q   <= s3_flags_d;
        end
    end

    assign o_nx = s3_flags_q.nx;
    assign o_of = s3_flags_q.of;
    assign o_uf = s3_flags_q.uf;
`else
    assign o_nx = 1'b0;
    assign o_of = 1'b0;
    assign o_uf = 1'b0;
`endif

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb/tb_fp_round_pipe.sv - directed-vector bench for fp_round_pipe at FPWID=16 (flags checked when FP_ROUND_FLAGS_EN)
module tb_fp_round_pipe;

`ifdef FP_ROUND_FLAGS_EN
    localparam bit FLG = 1'b1;
`else
    localparam bit FLG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [2:0]  rm = 3'd0;
    logic [19:0] i_in = '0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [15:0] o;
    logic        o_nx, o_of, o_uf;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [19:0] in;
        logic [2:0]  rm;
        logic [15:0] eo;
        logic        nx;
        logic        of;
        logic        uf;
    } vec_t;

    vec_t vec[21];

    fp_round_pipe #(.FPWID(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .rm      (rm),
        .i       (i_in),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o       (o),
        .o_nx    (o_nx),
        .o_of    (o_of),
        .o_uf    (o_uf)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input logic sg, input logic [4:0] e, input logic h,
                                       input logic [9:0] f, input logic [2:0] grs);
        return {sg, e, h, f, grs};
    endfunction

    function automatic vec_t v(input logic [19:0] in, input logic [2:0] m, input logic [15:0] eo,
                               input logic nx, input logic of, input logic uf);
        vec_t t;
        t.in = in; t.rm = m; t.eo = eo; t.nx = nx & FLG; t.of = of & FLG; t.uf = uf & FLG;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, sent, got, waitc;
        logic [15:0] hold;
        logic have_hold, stable_ok;
        logic [15:0] outs[5];

        vec[0]  = v(mk(0, 5'h0F, 1, 10'h000, 3'b100), 3'd0, 16'h3C00, 1, 0, 0);
        vec[1]  = v(mk(0, 5'h0F, 1, 10'h001, 3'b100), 3'd0, 16'h3C02, 1, 0, 0);
        vec[2]  = v(mk(0, 5'h1E, 1, 10'h3FF, 3'b100), 3'd0, 16'h7C00, 1, 1, 0);
        vec[3]  = v(mk(0, 5'h1E, 1, 10'h3FF, 3'b100), 3'd1, 16'h7BFF, 1, 0, 0);
        vec[4]  = v(mk(1, 5'h1E, 1, 10'h3FF, 3'b100), 3'd2, 16'hFBFF, 1, 0, 0);
        vec[5]  = v(mk(0, 5'h00, 0, 10'h3FF, 3'b110), 3'd0, 16'h0400, 1, 0, 0);
        vec[6]  = v(mk(0, 5'h00, 0, 10'h001, 3'b001), 3'd0, 16'h0001, 1, 0, 1);
        vec[7]  = v(mk(1, 5'h1F, 1, 10'h200, 3'b111), 3'd0, 16'hFE00, 0, 0, 0);
        vec[8]  = v(mk(1, 5'h1F, 1, 10'h200, 3'b111), 3'd3, 16'hFE00, 0, 0, 0);
        vec[9]  = v(mk(0, 5'h0F, 1, 10'h000, 3'b001), 3'd2, 16'h3C01, 1, 0, 0);
        vec[10] = v(mk(1, 5'h0F, 1, 10'h000, 3'b001), 3'd3, 16'hBC01, 1, 0, 0);
        vec[11] = v(mk(1, 5'h0F, 1, 10'h000, 3'b001), 3'd2, 16'hBC00, 1, 0, 0);
        vec[12] = v(mk(0, 5'h0F, 1, 10'h000, 3'b100), 3'd4, 16'h3C01, 1, 0, 0);
        vec[13] = v(mk(0, 5'h0F, 1, 10'h000, 3'b100), 3'd7, 16'h3C00, 1, 0, 0);
        vec[14] = v(mk(1, 5'h1E, 1, 10'h3FF, 3'b100), 3'd3, 16'hFC00, 1, 1, 0);
        vec[15] = v(mk(0, 5'h1E, 1, 10'h3FF, 3'b001), 3'd2, 16'h7C00, 1, 1, 0);
        vec[16] = v(mk(1, 5'h00, 0, 10'h000, 3'b000), 3'd0, 16'h8000, 0, 0, 0);
        vec[17] = v(mk(0, 5'h1E, 1, 10'h3FF, 3'b000), 3'd2, 16'h7BFF, 0, 0, 0);
        vec[18] = v(mk(0, 5'h0F, 1, 10'h001, 3'b011), 3'd0, 16'h3C01, 1, 0, 0);
        vec[19] = v(mk(0, 5'h0F, 1, 10'h000, 3'b110), 3'd0, 16'h3C01, 1, 0, 0);
        vec[20] = v(mk(1, 5'h1E, 1, 10'h3FF, 3'b100), 3'd4, 16'hFC00, 1, 1, 0);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_o", {16'd0, o}, 32'd0);
        chk("rst_flags", {29'd0, o_nx, o_of, o_uf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_i_ready", {31'd0, i_ready}, 32'd1);

        // table-driven single beats
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            i_valid = 1'b1; i_in = vec[k].in; rm = vec[k].rm;
            @(negedge clk);
            i_valid = 1'b0;
            lat = 0;
            while (!o_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("v%0d_lat", k), lat, 32'd2);
            chk($sformatf("v%0d_o", k), {16'd0, o}, {16'd0, vec[k].eo});
            chk($sformatf("v%0d_nx", k), {31'd0, o_nx}, {31'd0, vec[k].nx});
            chk($sformatf("v%0d_of", k), {31'd0, o_of}, {31'd0, vec[k].of});
            chk($sformatf("v%0d_uf", k), {31'd0, o_uf}, {31'd0, vec[k].uf});
        end
        @(negedge clk);
        chk("idle_o_valid", {31'd0, o_valid}, 32'd0);

        // backpressure: stall 6 cycles while offering 5 beats
        o_ready = 1'b0; sent = 0; got = 0; have_hold = 1'b0; stable_ok = 1'b1; hold = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (sent < 5) begin
                i_valid = 1'b1; i_in = vec[sent].in; rm = vec[sent].rm;
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (o_valid) begin
                if (!have_hold) begin
                    hold = o; have_hold = 1'b1;
                end else if (o !== hold) begin
                    stable_ok = 1'b0;
                end
            end
            if (i_valid && i_ready) sent++;
        end
        chk("bp_accepted", sent, 32'd3);
        chk("bp_i_ready", {31'd0, i_ready}, 32'd0);
        chk("bp_o_valid_seen", {31'd0, have_hold}, 32'd1);
        chk("bp_o_stable", {31'd0, stable_ok}, 32'd1);
        chk("bp_hold_val", {16'd0, hold}, {16'd0, vec[0].eo});
        for (int c = 0; c < 30 && got < 5; c++) begin
            @(negedge clk);
            o_ready = 1'b1;
            if (sent < 5) begin
                i_valid = 1'b1; i_in = vec[sent].in; rm = vec[sent].rm;
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (o_valid && o_ready) begin
                outs[got] = o; got++;
            end
            if (i_valid && i_ready) sent++;
        end
        i_valid = 1'b0;
        chk("bp_sent", sent, 32'd5);
        chk("bp_got", got, 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < got) chk($sformatf("bp_out%0d", k), {16'd0, outs[k]}, {16'd0, vec[k].eo});
        end
        repeat (2) @(negedge clk);
        chk("bp_no_dup", {31'd0, o_valid}, 32'd0);

        // reset with three beats in flight
        o_ready = 1'b0; sent = 0; waitc = 0;
        while (sent < 3 && waitc < 20) begin
            @(negedge clk);
            i_valid = 1'b1; i_in = vec[sent + 2].in; rm = vec[sent + 2].rm;
            #1;
            if (i_ready) sent++;
            waitc++;
        end
        @(negedge clk);
        i_valid = 1'b0;
        chk("ar_pre_sent", sent, 32'd3);
        chk("ar_pre_o_valid", {31'd0, o_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_o_valid", {31'd0, o_valid}, 32'd0);
        chk("ar_o", {16'd0, o}, 32'd0);
        chk("ar_flags", {29'd0, o_nx, o_of, o_uf}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ar_i_ready", {31'd0, i_ready}, 32'd1);
        o_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_valid) got++;
        end
        chk("ar_no_ghost", got, 32'd0);
        @(negedge clk);
        i_valid = 1'b1; i_in = vec[6].in; rm = vec[6].rm;
        @(negedge clk);
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("ar_post_lat", lat, 32'd2);
        chk("ar_post_o", {16'd0, o}, {16'd0, vec[6].eo});
        chk("ar_post_uf", {31'd0, o_uf}, {31'd0, vec[6].uf});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_round_pipe.md
# fp_round_pipe

Parametrised, pipelined IEEE-754 rounding unit that converts the intermediate result format (sign, exponent, hidden bit, fraction, G/R/S) to a packed IEEE value of width FPWID. It replaces the single-width combinational rounder and sits at the tail of the add/mul/div/fma datapaths. It adds a valid/ready handshake with backpressure, correct directed rounding on G|R|S, mode-dependent overflow saturation, and IEEE exception flags.

## Interface
- FPWID, 32: packed width; legal values are 16, 32, 64, 128. EXPWID/FRACWID are taken from the package function of FPWID: 5/10, 8/23, 11/52, 15/112.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- i_valid  in  1  input beat valid.
- i_ready  out  1  unit can accept a beat.
- rm  in  3  rounding mode, sampled with the beat: 0 RNE, 1 RTZ, 2 RUP, 3 RDN, 4 RMM; 5–7 are treated as RNE.
- i  in  FPWID+4  intermediate value, from MSB to LSB: {sign, exp[EXPWID], hid, frac[FRACWID], G, R, S}.
- o_valid  out  1  output beat valid.
- o_ready  in  1  downstream accepts.
- o  out  FPWID  rounded result {sign, exp, frac}.
- o_nx, o_of, o_uf  out  1 each  inexact, overflow and underflow flags, aligned with o.

## Operation
- L = frac[0]; inexact = G|R|S.
- Rounding increment:
  - RNE: G&(R|S|L).
  - RTZ: 0.
  - RUP: ~sign & inexact.
  - RDN: sign & inexact.
  - RMM: G.
- Inputs with exp all ones (Inf/NaN) pass through unchanged. They have no increment and no flags.
- Add the increment to {exp, frac} as one FPWID-1-bit unsigned sum. The carry out of the fraction increments the exponent, which also covers denormal→normal when exp=0 and the fraction is all ones.
- Overflow: the sum exponent is all ones and the input was finite. The result depends on mode:
  - RNE or RMM: ±Inf.
  - RTZ: ±max-finite.
  - RUP: +Inf for positive, -max-finite for negative.
  - RDN: -Inf for negative, +max-finite for positive.
  - o_of=1 and o_nx=1.
- Underflow uses tininess after rounding: the result exp is 0 and inexact=1. A denormal that rounds up to the minimum normal does not raise o_uf.
- Zero is preserved with its sign; the increment is 0 because G/R/S are 0.

## Timing
- Fixed latency of 3 cycles: S1 registers the input and computes the increment; S2 does the add; S3 applies overflow and flags and drives o.
- A beat transfers on i_valid&i_ready (input side) and o_valid&o_ready (output side).
- Each stage holds a valid bit. Stage k loads when it is empty or when stage k+1 loads or drains (bubble-collapsing). i_ready = ~S1.valid | S1 advances.
- Capacity is 3 beats. With o_ready held low, three beats are accepted, then i_ready=0.
- While o_valid=1 and o_ready=0, o and the flags stay stable.
- A simultaneous accept and drain at a full pipe sustains 1 beat per cycle.
- Reset, including mid-operation: all stage valids clear and o, flags and the datapath registers go to 0. i_ready=1 from the first clk after rst_n rises. In-flight beats are dropped.

## Configuration
- FP_ROUND_FLAGS_EN is defined: flag logic and the flag pipeline registers are built as above.
- FP_ROUND_FLAGS_EN is undefined: o_nx, o_of and o_uf are tied to 0 and no flag registers exist. Rounded values, including overflow saturation, are identical in both builds.

## Structure
- Shared fp package holds:
  - the rounding-mode enum;
  - the exception-flag struct {nx, of, uf};
  - functions giving EXPWID and FRACWID for a given FPWID.
- One sub-module, fp_round_decide: a combinational increment decision from {rm, sign, L, G, R, S, is_special}, instantiated in S1.

## Test plan
All cases use FPWID=16.
- Tie to even, RNE, i = {0, 0x0F, 1, 0x000, 100}: o=0x3C00, nx=1, of=0, uf=0. With L=1 (frac=0x001): o=0x3C02.
- Overflow, i = {0, 0x1E, 1, 0x3FF, 100}:
  - RNE: o=0x7C00, of=1, nx=1.
  - RTZ: o=0x7BFF.
  - Sign set, RUP: o=0xFBFF.
- Denormal promote, RNE, i = {0, 0x00, 0, 0x3FF, 110}: o=0x0400, nx=1, uf=0. With frac=0x001, GRS=001: o=0x0001, uf=1.
- Special passthrough, i = {1, 0x1F, 1, 0x200, 111}, any rm: o=0xFE00, all flags 0.
- Backpressure: o_ready=0 for 6 cycles while offering 5 beats. Expect 3 accepted, i_ready=0 after that, o held stable. Release o_ready and expect all 5 beats out in order with no loss or duplicates.
- Reset with 3 beats in flight: pull rst_n low asynchronously. Expect o_valid=0 and o=0 immediately, and i_ready=1 one cycle after release.
